// File: rtl/fp_hs_pkg.sv
// Shared definitions for the FP handshake issuer: state encoding,
// abort result value and the width of the cycle counter.
package fp_hs_pkg;

    localparam int CYC_W = 16;

    localparam logic [31:0] QNAN = 32'hFFC00000;

    typedef logic [2:0] state_t;

    localparam state_t S_IDLE   = 3'd0;
    localparam state_t S_SEND_A = 3'd1;
    localparam state_t S_SEND_B = 3'd2;
    localparam state_t S_WAIT_Z = 3'd3;
    localparam state_t S_RESP   = 3'd4;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
    } operands_t;

endpackage

// File: rtl/fp_hs_timer.sv
// Per-command cycle timer: synchronous clear, count enable, saturation
// at all-ones and an expiry flag raised on the last allowed cycle.
module fp_hs_timer #(
    parameter int TIMEOUT = 255,
    parameter int W       = 16
) (
    input  logic         clk,
    input  logic         rstnn,
    input  logic         clr_i,
    input  logic         en_i,
    output logic [W-1:0] cnt_o,
    output logic         expired_o
);

    // With TIMEOUT == 0 the compare value is irrelevant: expiry is gated off.
    localparam logic [W-1:0] LAST = (TIMEOUT > 0) ? W'(TIMEOUT - 1) : '0;

    logic [W-1:0] cnt_q, cnt_d;

    // Next count: clear wins, otherwise count up and stick at all-ones.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i)
            cnt_d = '0;
        else if (en_i && (cnt_q != '1))
            cnt_d = cnt_q + 1'b1;
    end

    // Counter register.
    always_ff @(posedge clk or negedge rstnn) begin
        if (!rstnn)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end

    assign cnt_o     = cnt_q;
    assign expired_o = (TIMEOUT > 0) && en_i && (cnt_q == LAST);

endmodule

// File: rtl/fp_hs_issuer.sv
// Issues one operand pair to a strobe/ack FP unit, collects the result
// and returns it with the command tag; aborts with a quiet NaN when the
// unit takes too long.
module fp_hs_issuer
    import fp_hs_pkg::*;
#(
    parameter int TIMEOUT = 255,
    parameter int TAG_W   = 4
) (
    input  logic             clk,
    input  logic             rstnn,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [31:0]      cmd_a,
    input  logic [31:0]      cmd_b,
    input  logic [TAG_W-1:0] cmd_tag,
    output logic [31:0]      fpu_a,
    output logic [31:0]      fpu_b,
    output logic             fpu_a_stb,
    output logic             fpu_b_stb,
    input  logic             fpu_a_ack,
    input  logic             fpu_b_ack,
    input  logic [31:0]      fpu_z,
    input  logic             fpu_z_stb,
    output logic             fpu_z_ack,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [31:0]      rsp_z,
    output logic [TAG_W-1:0] rsp_tag,
    output logic             rsp_timeout,
    output logic [15:0]      rsp_cycles,
    output logic             busy
);

    state_t           state_q, state_d;
    operands_t        ops_q, ops_d;
    logic [TAG_W-1:0] tag_q, tag_d;
    logic [31:0]      z_q, z_d;
    logic             to_q, to_d;

    logic             accept, a_xfer, b_xfer, z_xfer;
    logic             timing, expired, abort;
    logic [CYC_W-1:0] cyc;

    assign accept = (state_q == S_IDLE)   && cmd_valid;
    assign a_xfer = (state_q == S_SEND_A) && fpu_a_ack;
    assign b_xfer = (state_q == S_SEND_B) && fpu_b_ack;
    assign z_xfer = (state_q == S_WAIT_Z) && fpu_z_stb;
    assign timing = (state_q == S_SEND_A) || (state_q == S_SEND_B) ||
                    (state_q == S_WAIT_Z);
    // A transfer on the expiry edge takes priority over the abort.
    assign abort  = expired && !(a_xfer || b_xfer || z_xfer);

    // The timer doubles as the acceptance-to-capture cycle count: it is
    // cleared on accept, runs through all three phases and freezes in RESP.
    fp_hs_timer #(
        .TIMEOUT (TIMEOUT),
        .W       (CYC_W)
    ) u_timer (
        .clk       (clk),
        .rstnn     (rstnn),
        .clr_i     (accept),
        .en_i      (timing),
        .cnt_o     (cyc),
        .expired_o (expired)
    );

    // Next-state decode for the issue sequence.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (cmd_valid) state_d = S_SEND_A;
            S_SEND_A: if (a_xfer) state_d = S_SEND_B;
                      else if (abort) state_d = S_RESP;
            S_SEND_B: if (b_xfer) state_d = S_WAIT_Z;
                      else if (abort) state_d = S_RESP;
            S_WAIT_Z: if (z_xfer || abort) state_d = S_RESP;
            S_RESP:   if (rsp_ready) state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // Next data: operands/tag on accept, result on capture or abort.
    always_comb begin
        ops_d = ops_q;
        tag_d = tag_q;
        z_d   = z_q;
        to_d  = to_q;
        if (accept) begin
            ops_d.a = cmd_a;
            ops_d.b = cmd_b;
            tag_d   = cmd_tag;
        end
        if (z_xfer) begin
            z_d  = fpu_z;
            to_d = 1'b0;
        end else if (abort) begin
            z_d  = QNAN;
            to_d = 1'b1;
        end
    end

    // State and data registers.
    always_ff @(posedge clk or negedge rstnn) begin
        if (!rstnn) begin
            state_q <= S_IDLE;
            ops_q   <= '0;
            tag_q   <= '0;
            z_q     <= '0;
            to_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            ops_q   <= ops_d;
            tag_q   <= tag_d;
            z_q     <= z_d;
            to_q    <= to_d;
        end
    end

    assign cmd_ready   = (state_q == S_IDLE);
    assign busy        = (state_q != S_IDLE);
    assign fpu_a_stb   = (state_q == S_SEND_A);
    assign fpu_b_stb   = (state_q == S_SEND_B);
    assign fpu_z_ack   = (state_q == S_WAIT_Z);
    assign rsp_valid   = (state_q == S_RESP);
    assign fpu_a       = ops_q.a;
    assign fpu_b       = ops_q.b;
    assign rsp_z       = z_q;
    assign rsp_tag     = tag_q;
    assign rsp_timeout = to_q;
    assign rsp_cycles  = cyc;

endmodule

// File: tb/tb_fp_hs_issuer.sv
// Directed bench for fp_hs_issuer with a behavioural FP unit whose ack and
// result delays are set per step; responses are checked from a scoreboard.
module tb_fp_hs_issuer;

    localparam int TO = 10;

    logic        clk = 1'b0;
    logic        rstnn = 1'b0;
    logic        cmd_valid = 1'b0, cmd_ready;
    logic [31:0] cmd_a = '0, cmd_b = '0;
    logic [3:0]  cmd_tag = '0;
    logic [31:0] fpu_a, fpu_b, fpu_z;
    logic        fpu_a_stb, fpu_b_stb, fpu_a_ack, fpu_b_ack;
    logic        fpu_z_stb, fpu_z_ack;
    logic        rsp_valid, rsp_ready = 1'b0, rsp_timeout, busy;
    logic [31:0] rsp_z;
    logic [3:0]  rsp_tag;
    logic [15:0] rsp_cycles;

    int checks = 0;
    int errors = 0;

    // FP unit model configuration (written only by the stimulus)
    int   a_delay = 1, b_delay = 1, z_delay = 1;
    logic z_never = 1'b0;

    // FP unit model observations (written only by the model)
    int          a_xfers = 0, a_len = 0, a_unstable = 0;
    logic [31:0] lat_a = '0, lat_b = '0;

    typedef struct {
        logic [31:0] z;
        logic [3:0]  tag;
        logic        to;
        logic [15:0] cyc;
    } exp_t;
    exp_t sb[$];

    fp_hs_issuer #(.TIMEOUT(TO), .TAG_W(4)) dut (
        .clk         (clk),
        .rstnn       (rstnn),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_a       (cmd_a),
        .cmd_b       (cmd_b),
        .cmd_tag     (cmd_tag),
        .fpu_a       (fpu_a),
        .fpu_b       (fpu_b),
        .fpu_a_stb   (fpu_a_stb),
        .fpu_b_stb   (fpu_b_stb),
        .fpu_a_ack   (fpu_a_ack),
        .fpu_b_ack   (fpu_b_ack),
        .fpu_z       (fpu_z),
        .fpu_z_stb   (fpu_z_stb),
        .fpu_z_ack   (fpu_z_ack),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_z       (rsp_z),
        .rsp_tag     (rsp_tag),
        .rsp_timeout (rsp_timeout),
        .rsp_cycles  (rsp_cycles),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    // Divider lookup for the operand pairs used here; anything else gets a
    // recognisable non-quotient so a mis-routed operand shows up.
    function automatic logic [31:0] fdiv(input logic [31:0] a, input logic [31:0] b);
        if (a == 32'h40C00000 && b == 32'h40000000) return 32'h40400000; //  6 /  2
        if (a == 32'h3F800000 && b == 32'h40000000) return 32'h3F000000; //  1 /  2
        if (a == 32'h41000000 && b == 32'hC0000000) return 32'hC0800000; //  8 / -2
        return a ^ b;
    endfunction

    // FP unit model, evaluated on falling edges.
    logic [31:0] a_first;
    int          a_cnt, b_cnt, z_cnt;
    initial begin
        fpu_a_ack = 1'b0; fpu_b_ack = 1'b0; fpu_z_stb = 1'b0; fpu_z = '0;
        a_first = '0; a_cnt = 0; b_cnt = 0; z_cnt = 0;
        forever begin
            @(negedge clk);
            if (!rstnn) begin
                fpu_a_ack = 1'b0; fpu_b_ack = 1'b0; fpu_z_stb = 1'b0;
                a_cnt = 0; b_cnt = 0; z_cnt = 0;
            end else begin
                if (fpu_a_stb) begin
                    if (a_cnt == 0) a_first = fpu_a;
                    else if (fpu_a !== a_first) a_unstable++;
                    a_cnt++;
                    a_len = a_cnt;
                    fpu_a_ack = (a_cnt >= a_delay);
                    if (fpu_a_ack) begin a_xfers++; lat_a = fpu_a; end
                end else begin
                    a_cnt = 0; fpu_a_ack = 1'b0;
                end
                if (fpu_b_stb) begin
                    b_cnt++;
                    fpu_b_ack = (b_cnt >= b_delay);
                    if (fpu_b_ack) lat_b = fpu_b;
                end else begin
                    b_cnt = 0; fpu_b_ack = 1'b0;
                end
                if (fpu_z_ack) begin
                    z_cnt++;
                    fpu_z_stb = !z_never && (z_cnt >= z_delay);
                    fpu_z = fdiv(lat_a, lat_b);
                end else begin
                    z_cnt = 0; fpu_z_stb = 1'b0;
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", name, obs, exp);
        end
    endtask

    // Offer a command at a falling edge; returns at the falling edge after acceptance.
    task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic [3:0] tag,
                         input logic [31:0] ez, input logic eto, input int ecyc);
        exp_t e;
        int   n;
        cmd_a = a; cmd_b = b; cmd_tag = tag; cmd_valid = 1'b1;
        n = 0;
        while (cmd_ready !== 1'b1 && n < 50) begin @(negedge clk); n++; end
        chk("cmd_ready", cmd_ready, 1'b1);
        @(negedge clk);
        cmd_valid = 1'b0;
        e.z = ez; e.tag = tag; e.to = eto; e.cyc = 16'(ecyc);
        sb.push_back(e);
    endtask

    // Wait for the response, check it for hold+1 cycles, then handshake.
    task automatic get_rsp(input int hold, input logic overlap);
        exp_t e;
        int   lat;
        lat = 0;
        while (rsp_valid !== 1'b1 && lat < 300) begin @(negedge clk); lat++; end
        chk("rsp_valid", rsp_valid, 1'b1);
        checks++;
        assert (sb.size() > 0) else begin
            errors++;
            $error("FAIL scoreboard: observed response, expected none");
        end
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk("latency", lat, 32'(e.cyc));
            for (int i = 0; i <= hold; i++) begin
                chk("rsp_z", rsp_z, e.z);
                chk("rsp_tag", rsp_tag, e.tag);
                chk("rsp_timeout", rsp_timeout, e.to);
                chk("rsp_cycles", rsp_cycles, e.cyc);
                chk("rsp_hold_valid", rsp_valid, 1'b1);
                chk("rsp_cmd_ready", cmd_ready, 1'b0);
                chk("rsp_busy", busy, 1'b1);
                if (i < hold) @(negedge clk);
            end
        end
        rsp_ready = 1'b1;
        if (overlap) cmd_valid = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        chk("rsp_drop", rsp_valid, 1'b0);
        chk("idle_busy", busy, 1'b0);
        chk("idle_ready", cmd_ready, 1'b1);
    endtask

    // Overall time bound.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not reach the end");
        $fatal(1);
    end

    initial begin
        int xf0, un0, seen;

        // Reset state
        #2;
        chk("reset_cmd_ready", cmd_ready, 1'b1);
        chk("reset_busy", busy, 1'b0);
        chk("reset_stb", {fpu_a_stb, fpu_b_stb, fpu_z_ack, rsp_valid}, 4'b0000);
        chk("reset_cycles", rsp_cycles, 16'h0);
        chk("reset_rsp_z", rsp_z, 32'h0);
        repeat (2) @(negedge clk);
        rstnn = 1'b1;
        @(negedge clk);

        // Divider 6/2, acks already high, result in first WAIT_Z cycle: 3 cycles
        a_delay = 1; b_delay = 1; z_delay = 1; z_never = 1'b0;
        issue(32'h40C00000, 32'h40000000, 4'd3, 32'h40400000, 1'b0, 3);
        get_rsp(0, 1'b0);

        // 1/2 with slow B ack and a late result
        b_delay = 3; z_delay = 2;
        issue(32'h3F800000, 32'h40000000, 4'd9, 32'h3F000000, 1'b0, 6);
        get_rsp(0, 1'b0);

        // A ack delayed: strobe held 5 cycles, operand stable, one transfer
        a_delay = 5; b_delay = 1; z_delay = 1;
        xf0 = a_xfers; un0 = a_unstable;
        issue(32'h41000000, 32'hC0000000, 4'd5, 32'hC0800000, 1'b0, 7);
        get_rsp(0, 1'b0);
        chk("a_stb_len", a_len, 5);
        chk("a_xfers", a_xfers - xf0, 1);
        chk("a_stable", a_unstable - un0, 0);

        // Result never arrives: abort after TIMEOUT edges
        a_delay = 1; z_never = 1'b1;
        issue(32'h40C00000, 32'h40000000, 4'd7, 32'hFFC00000, 1'b1, TO);
        get_rsp(0, 1'b0);

        // A ack never arrives: abort while still in SEND_A
        a_delay = 50; z_never = 1'b0;
        issue(32'h3F800000, 32'h40000000, 4'd2, 32'hFFC00000, 1'b1, TO);
        get_rsp(0, 1'b0);

        // Result strobe on the expiry edge: transfer wins
        a_delay = 1; z_delay = 8;
        issue(32'h12345678, 32'h0F0F0F0F, 4'd11, 32'h1D3B5977, 1'b0, TO);
        get_rsp(0, 1'b0);

        // Reset pulsed during WAIT_Z
        z_never = 1'b1;
        issue(32'h40C00000, 32'h40000000, 4'd6, 32'hFFC00000, 1'b1, TO);
        repeat (3) @(negedge clk);
        chk("in_wait_z", fpu_z_ack, 1'b1);
        rstnn = 1'b0;
        #1;
        chk("mid_rst_ready", cmd_ready, 1'b1);
        chk("mid_rst_busy", busy, 1'b0);
        chk("mid_rst_stb", {fpu_a_stb, fpu_b_stb, fpu_z_ack, rsp_valid, rsp_timeout}, 5'b0);
        chk("mid_rst_cycles", rsp_cycles, 16'h0);
        chk("mid_rst_fpu_a", fpu_a, 32'h0);
        chk("mid_rst_fpu_b", fpu_b, 32'h0);
        chk("mid_rst_rsp_z", rsp_z, 32'h0);
        chk("mid_rst_tag", rsp_tag, 4'h0);
        void'(sb.pop_back());
        @(negedge clk);
        rstnn = 1'b1;
        z_never = 1'b0; z_delay = 1;
        seen = 0;
        repeat (15) begin
            @(negedge clk);
            if (rsp_valid === 1'b1 || busy === 1'b1) seen++;
        end
        chk("no_rsp_after_rst", seen, 0);
        issue(32'h40C00000, 32'h40000000, 4'd4, 32'h40400000, 1'b0, 3);
        get_rsp(0, 1'b0);

        // Back-pressure: response held 20 cycles; a command offered in the
        // handshake cycle is only taken on the following edge
        issue(32'h3F800000, 32'h40000000, 4'd1, 32'h3F000000, 1'b0, 3);
        cmd_a = 32'h41000000; cmd_b = 32'hC0000000; cmd_tag = 4'd15;
        get_rsp(20, 1'b1);
        issue(32'h41000000, 32'hC0000000, 4'd15, 32'hC0800000, 1'b0, 3);
        get_rsp(0, 1'b0);

        chk("sb_drained", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fp_hs_issuer.md
FP_HS_ISSUER -- requirements
Module: fp_hs_issuer

Interface
REQ-001 SHALL have parameter TIMEOUT, default 255, cycles allowed per command before abort; 0 disables the timeout.
REQ-002 SHALL have parameter TAG_W, default 4, width of the command tag.
REQ-003 clk  in  1  clock.
REQ-004 rstnn  in  1  reset, asynchronous, active-low.
REQ-005 cmd_valid  in  1  command pair offered.
REQ-006 cmd_ready  out  1  issuer can accept a command.
REQ-007 cmd_a, cmd_b  in  32  IEEE-754 single operands.
REQ-008 cmd_tag  in  TAG_W  user tag returned with the result.
REQ-009 fpu_a, fpu_b  out  32  operands driven to the FP unit.
REQ-010 fpu_a_stb, fpu_b_stb  out  1  operand strobes; fpu_a_ack, fpu_b_ack  in  1  unit acknowledges.
REQ-011 fpu_z  in  32  result; fpu_z_stb  in  1  result strobe; fpu_z_ack  out  1  result accepted.
REQ-012 rsp_valid  out  1; rsp_ready  in  1; rsp_z  out  32; rsp_tag  out  TAG_W; rsp_timeout  out  1; rsp_cycles  out  16.
REQ-013 busy  out  1  high whenever the state is not IDLE.

Function
REQ-014 SHALL implement states IDLE, SEND_A, SEND_B, WAIT_Z, RESP.
REQ-015 cmd_ready SHALL be 1 only in IDLE; on clk edge with cmd_valid&&cmd_ready, latch cmd_a/cmd_b/cmd_tag, clear timer and cycle counter, go SEND_A.
REQ-016 fpu_a_stb SHALL be 1 exactly in SEND_A, with fpu_a = latched cmd_a held stable.
REQ-017 A/B/Z transfer SHALL occur on a clk edge where that strobe and its ack are both 1; SEND_A->SEND_B on the A transfer; SEND_B->WAIT_Z on the B transfer.
REQ-018 fpu_b_stb SHALL be 1 exactly in SEND_B, with fpu_b = latched cmd_b.
REQ-019 fpu_z_ack SHALL be 1 exactly in WAIT_Z; on the Z transfer, capture fpu_z into rsp_z, set rsp_timeout=0, go RESP.
REQ-020 rsp_valid SHALL be 1 exactly in RESP, with rsp_z/rsp_tag/rsp_timeout/rsp_cycles held stable; on rsp_valid&&rsp_ready, go IDLE.
REQ-021 The minimum command-accept-to-rsp_valid latency SHALL be 3 cycles when the acks are already high and fpu_z_stb rises in the first WAIT_Z cycle.
REQ-022 rsp_cycles SHALL count the clk edges from command acceptance to Z capture (or abort), saturating at 16'hFFFF without wrapping.
REQ-023 The timer SHALL increment once per cycle in SEND_A, SEND_B and WAIT_Z and SHALL not reset between phases.
REQ-024 If TIMEOUT>0 and the timer equals TIMEOUT-1 at an edge with no transfer, go RESP with rsp_z=32'hFFC00000 and rsp_timeout=1.
REQ-025 When a transfer and timeout expiry fall on the same edge, the transfer SHALL win.
REQ-026 All strobes and fpu_z_ack SHALL drop in the cycle after their transfer; a strobe SHALL never be withdrawn before its transfer except by timeout or reset.
REQ-027 A new command SHALL not be accepted in the same cycle as the response handshake; the earliest acceptance is the next cycle.

Reset
REQ-028 rstnn low SHALL immediately force IDLE and set cmd_ready=1, and set to 0 all strobes, fpu_z_ack, rsp_valid, rsp_timeout, busy, rsp_cycles, the timer and all data registers.
REQ-029 Reset asserted mid-command SHALL abandon the command; no response SHALL be produced for it.

Structure
REQ-030 Shared package fp_hs_pkg SHALL hold the state encoding, the QNAN constant 32'hFFC00000 and the rsp_cycles width.
REQ-031 A single sub-module fp_hs_timer (load-clear, enable, saturating count, expiry compare) SHALL be used.

Verification
REQ-032 Connected to the divider, cmd_a=0x40C00000, cmd_b=0x40000000, tag 3 -> rsp_z=0x40400000, rsp_tag=3, rsp_timeout=0.
REQ-033 Model with fpu_a_ack delayed 5 cycles -> fpu_a_stb held 5 cycles, fpu_a constant throughout, exactly one A transfer.
REQ-034 TIMEOUT=10 with fpu_z_stb never raised -> rsp_valid, rsp_z=0xFFC00000, rsp_timeout=1, rsp_cycles=10.
REQ-035 TIMEOUT=10 with fpu_z_stb rising on the expiry edge -> normal result, rsp_timeout=0.
REQ-036 rstnn pulsed during WAIT_Z -> all outputs reset, no rsp_valid, next command completes normally.
REQ-037 rsp_ready held low 20 cycles -> response held stable; cmd_ready=0 until the response handshake.
